// File: rtl/light_display_scan.sv
// Multiplexed 4-digit common-anode display driver for two traffic-light roads.
// Inputs are snapshotted once per frame; yellow blinks and illegal light codes show dashes.
module light_display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_a,
  input  logic [3:0] tens_a,
  input  logic [3:0] ones_a,
  input  logic [2:0] light_b,
  input  logic [3:0] tens_b,
  input  logic [3:0] ones_b,
  output logic [6:0] seg,
  output logic [3:0] dig_en,
  output logic [2:0] led_a,
  output logic [2:0] led_b,
  output logic       frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PcntMax  = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BlinkMax = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0] SegDash  = 7'h3F;
  localparam logic [6:0] SegBlank = 7'h7F;

  // Active-low gfedcba pattern for one 4-bit value.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      4'd15:   s = SegBlank;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  function automatic logic light_ok(input logic [2:0] l);
    return (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
  endfunction

  // Lamp outputs {red,yellow,green}; a faulty code blinks red.
  function automatic logic [2:0] lamp_drive(input logic [2:0] l, input logic phase);
    logic [2:0] r;
    case (l)
      3'b001:  r = 3'b001;
      3'b100:  r = 3'b100;
      3'b010:  r = {1'b0, phase, 1'b0};
      default: r = {phase, 2'b00};
    endcase
    return r;
  endfunction

  // Scan state
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Frame snapshot
  logic [2:0] snap_light_a_q, snap_light_a_d;
  logic [3:0] snap_tens_a_q, snap_tens_a_d;
  logic [3:0] snap_ones_a_q, snap_ones_a_d;
  logic [2:0] snap_light_b_q, snap_light_b_d;
  logic [3:0] snap_tens_b_q, snap_tens_b_d;
  logic [3:0] snap_ones_b_q, snap_ones_b_d;

  // Registered outputs
  logic [6:0] seg_q, seg_d;
  logic [3:0] dig_en_q, dig_en_d;
  logic [2:0] led_a_q, led_a_d;
  logic [2:0] led_b_q, led_b_d;
  logic       frame_tick_q, frame_tick_d;

  logic       slot_end;
  logic       frame_end;
  logic [3:0] cur_val;
  logic       cur_is_tens;
  logic       cur_fault;

  always_comb begin
    slot_end  = (pcnt_q == PcntMax);
    frame_end = slot_end && (slot_q == 2'd3);

    pcnt_d = slot_end ? '0 : pcnt_q + PW'(1);
    slot_d = slot_end ? slot_q + 2'd1 : slot_q;

    snap_light_a_d = snap_light_a_q;
    snap_tens_a_d  = snap_tens_a_q;
    snap_ones_a_d  = snap_ones_a_q;
    snap_light_b_d = snap_light_b_q;
    snap_tens_b_d  = snap_tens_b_q;
    snap_ones_b_d  = snap_ones_b_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;

    if (frame_end) begin
      snap_light_a_d = light_a;
      snap_tens_a_d  = tens_a;
      snap_ones_a_d  = ones_a;
      snap_light_b_d = light_b;
      snap_tens_b_d  = tens_b;
      snap_ones_b_d  = ones_b;
      // Counted at frame end so the phase changes together with the snapshot.
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    frame_tick_d = frame_end;

    // Outputs are built from next-state so they line up with the slot they describe.
    cur_val     = 4'hF;
    cur_is_tens = 1'b0;
    cur_fault   = 1'b0;
    case (slot_d)
      2'd0: begin
        cur_val     = snap_tens_a_d;
        cur_is_tens = 1'b1;
        cur_fault   = !light_ok(snap_light_a_d);
      end
      2'd1: begin
        cur_val   = snap_ones_a_d;
        cur_fault = !light_ok(snap_light_a_d);
      end
      2'd2: begin
        cur_val     = snap_tens_b_d;
        cur_is_tens = 1'b1;
        cur_fault   = !light_ok(snap_light_b_d);
      end
      default: begin
        cur_val   = snap_ones_b_d;
        cur_fault = !light_ok(snap_light_b_d);
      end
    endcase

    if (cur_fault) begin
      seg_d = SegDash;
    end else if (cur_is_tens && (cur_val == 4'd0)) begin
      seg_d = SegBlank;
    end else begin
      seg_d = seg_decode(cur_val);
    end

    // First cycle of each slot keeps all digits dark to suppress ghosting.
    if (pcnt_d == '0) begin
      dig_en_d = 4'hF;
    end else begin
      dig_en_d = ~(4'b0001 << slot_d);
    end

    led_a_d = lamp_drive(snap_light_a_d, blink_phase_d);
    led_b_d = lamp_drive(snap_light_b_d, blink_phase_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q         <= '0;
      slot_q         <= 2'd0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      snap_light_a_q <= 3'b000;
      snap_tens_a_q  <= 4'hF;
      snap_ones_a_q  <= 4'hF;
      snap_light_b_q <= 3'b000;
      snap_tens_b_q  <= 4'hF;
      snap_ones_b_q  <= 4'hF;
      seg_q          <= SegBlank;
      dig_en_q       <= 4'hF;
      led_a_q        <= 3'b000;
      led_b_q        <= 3'b000;
      frame_tick_q   <= 1'b0;
    end else begin
      pcnt_q         <= pcnt_d;
      slot_q         <= slot_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      snap_light_a_q <= snap_light_a_d;
      snap_tens_a_q  <= snap_tens_a_d;
      snap_ones_a_q  <= snap_ones_a_d;
      snap_light_b_q <= snap_light_b_d;
      snap_tens_b_q  <= snap_tens_b_d;
      snap_ones_b_q  <= snap_ones_b_d;
      seg_q          <= seg_d;
      dig_en_q       <= dig_en_d;
      led_a_q        <= led_a_d;
      led_b_q        <= led_b_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign led_a      = led_a_q;
  assign led_b      = led_b_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_light_display_scan.sv
// Directed + random bench for light_display_scan with a frame-level reference model.
module tb_light_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light_a = 3'b000, light_b = 3'b000;
  logic [3:0] tens_a = 4'h0, ones_a = 4'h0, tens_b = 4'h0, ones_b = 4'h0;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic [2:0] led_a, led_b;
  logic       frame_tick;

  always #5 clk = ~clk;

  light_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .light_a(light_a), .tens_a(tens_a), .ones_a(ones_a),
    .light_b(light_b), .tens_b(tens_b), .ones_b(ones_b),
    .seg(seg), .dig_en(dig_en), .led_a(led_a), .led_b(led_b),
    .frame_tick(frame_tick)
  );

  int total = 0;
  int bad = 0;
  int t;      // cycles since reset release; 0 = first cycle with rst high
  int ticks;  // frame ticks delivered since reset

  logic [2:0] m_light[2];
  logic [3:0] m_tens[2];
  logic [3:0] m_ones[2];
  logic [6:0] segtab[16];

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_digit(input int road, input bit is_tens);
    logic [3:0] v;
    if (!(m_light[road] inside {3'b001, 3'b010, 3'b100})) return 7'h3F;
    v = is_tens ? m_tens[road] : m_ones[road];
    if (is_tens && v == 4'd0) return 7'h7F;
    return segtab[v];
  endfunction

  function automatic logic [2:0] exp_led(input int road);
    logic ph;
    ph = ((ticks / BF) % 2) != 0;
    case (m_light[road])
      3'b001:  return 3'b001;
      3'b100:  return 3'b100;
      3'b010:  return {1'b0, ph, 1'b0};
      default: return {ph, 2'b00};
    endcase
  endfunction

  task automatic check_reset();
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dig", {3'b0, dig_en}, 7'h0F);
    chk("rst_led_a", {4'b0, led_a}, 7'h00);
    chk("rst_led_b", {4'b0, led_b}, 7'h00);
    chk("rst_tick", {6'b0, frame_tick}, 7'h00);
  endtask

  // Advance one cycle and compare all outputs against the model.
  task automatic cyc();
    int p, s;
    logic [3:0] de;
    logic [6:0] es;
    if (t >= 1 && ((t - 1) % FRAME) == FRAME - 1) begin
      m_light[0] = light_a; m_tens[0] = tens_a; m_ones[0] = ones_a;
      m_light[1] = light_b; m_tens[1] = tens_b; m_ones[1] = ones_b;
      ticks++;
    end
    @(negedge clk);
    p = t % SD;
    s = (t / SD) % 4;
    de = (p == 0) ? 4'hF : ~(4'b0001 << s);
    case (s)
      0:       es = exp_digit(0, 1'b1);
      1:       es = exp_digit(0, 1'b0);
      2:       es = exp_digit(1, 1'b1);
      default: es = exp_digit(1, 1'b0);
    endcase
    chk("seg", seg, es);
    chk("dig_en", {3'b0, dig_en}, {3'b0, de});
    chk("led_a", {4'b0, led_a}, {4'b0, exp_led(0)});
    chk("led_b", {4'b0, led_b}, {4'b0, exp_led(1)});
    chk("frame_tick", {6'b0, frame_tick}, {6'b0, (t > 0) && (t % FRAME == 0)});
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_reset();
    end
    rst = 1'b1;
    t = 1;
    ticks = 0;
    for (int r = 0; r < 2; r++) begin
      m_light[r] = 3'b000; m_tens[r] = 4'hF; m_ones[r] = 4'hF;
    end
  endtask

  task automatic rand_inputs();
    light_a = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
    light_b = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
    tens_a = 4'($urandom); ones_a = 4'($urandom);
    tens_b = 4'($urandom); ones_b = 4'($urandom);
  endtask

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F};
    t = 0;
    ticks = 0;

    // Reset with random inputs
    rand_inputs();
    do_reset(5);

    // Normal display
    light_a = 3'b001; tens_a = 4'd2; ones_a = 4'd5;
    light_b = 3'b100; tens_b = 4'd0; ones_b = 4'd7;
    run(2 * FRAME);

    // Anti-tear: change ones_a during slot 2
    while ((t % FRAME) != 2 * SD + 1) cyc();
    ones_a = 4'd3;
    run(2 * FRAME);

    // Yellow blink on road A
    light_a = 3'b010;
    run(6 * FRAME);

    // Fault on road B only
    light_b = 3'b011; tens_b = 4'd1; ones_b = 4'd2;
    run(5 * FRAME);

    // Invalid digits on road A
    light_a = 3'b001; tens_a = 4'd12; ones_a = 4'd15;
    run(3 * FRAME);

    // Reset during slot 1, then confirm the scan restarts cleanly
    while ((t % FRAME) != SD + 1) cyc();
    do_reset(1);
    run(3 * FRAME);

    // Random inputs changing at arbitrary points, with occasional random resets
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < FRAME; i++) begin
        if ($urandom_range(0, 5) == 0) rand_inputs();
        cyc();
      end
      if ($urandom_range(0, 9) == 0) begin
        run($urandom_range(0, FRAME - 1));
        do_reset($urandom_range(1, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
